// File: rtl/array_scan_table.sv
// array_scan_table: register-array table that fills itself with an arithmetic
// sequence after reset, then serves single reads, writes and an
// auto-incrementing scan from a start index up to the last entry.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   ready      out  high once the fill is complete
//   rd_en      in   single-read request (IDLE only)
//   rd_index   in   read index (clamped to DEPTH-1)
//   wr_en      in   write request (IDLE or SCAN)
//   wr_index   in   write index (out of range -> rejected)
//   wr_data    in   write data
//   wr_err     out  one-cycle pulse: write rejected
//   scan_start in   start a scan (IDLE only, wins over rd_en)
//   scan_index in   first scan index (clamped to DEPTH-1)
//   scan_busy  out  scan in progress
//   out_valid  out  out_data valid this cycle
//   out_data   out  read or scan data
//   out_oob    out  requested index was >= DEPTH, data clamped
module array_scan_table #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INDEX_W   = 32,
  parameter int unsigned INIT_BASE = 1,
  parameter int unsigned INIT_STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ready,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               wr_err,
  input  logic               scan_start,
  input  logic [INDEX_W-1:0] scan_index,
  output logic               scan_busy,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_oob
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Scan pointer needs one extra code to mark "past the last entry".
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam logic [INDEX_W:0] DEPTH_X = (INDEX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SCAN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    cnt;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] init_val;
  logic             wr_ok;

  // Unsigned full-width range check.
  function automatic logic is_oob(input logic [INDEX_W-1:0] idx);
    return {1'b0, idx} >= DEPTH_X;
  endfunction

  function automatic logic [AW-1:0] clamp(input logic [INDEX_W-1:0] idx);
    return is_oob(idx) ? AW'(DEPTH - 1) : AW'(idx);
  endfunction

  assign init_val = WIDTH'(INIT_BASE) + WIDTH'(cnt) * WIDTH'(INIT_STEP);
  assign wr_ok    = wr_en && (state != S_INIT) && !is_oob(wr_index);

  // Storage: fill during INIT, user writes afterwards (reads see old value).
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= init_val;
    end else if (wr_ok) begin
      mem[AW'(wr_index)] <= wr_data;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      cnt       <= '0;
      ptr       <= '0;
      ready     <= 1'b0;
      scan_busy <= 1'b0;
      out_valid <= 1'b0;
      out_oob   <= 1'b0;
      out_data  <= '0;
      wr_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_oob   <= 1'b0;
      wr_err    <= wr_en && (state != S_INIT) && is_oob(wr_index);
      case (state)
        S_INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (scan_start) begin
            // First beat leaves together with the start; an out-of-range
            // start emits a single clamped beat and never enters SCAN.
            out_valid <= 1'b1;
            out_data  <= mem[clamp(scan_index)];
            if (is_oob(scan_index)) begin
              out_oob <= 1'b1;
            end else begin
              state     <= S_SCAN;
              scan_busy <= 1'b1;
              ptr       <= PW'(clamp(scan_index)) + PW'(1);
            end
          end else if (rd_en) begin
            out_valid <= 1'b1;
            out_data  <= mem[clamp(rd_index)];
            out_oob   <= is_oob(rd_index);
          end
        end
        S_SCAN: begin
          if (ptr == PW'(DEPTH)) begin
            state     <= S_IDLE;
            scan_busy <= 1'b0;
          end else begin
            out_valid <= 1'b1;
            out_data  <= mem[AW'(ptr)];
            ptr       <= ptr + PW'(1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_array_scan_table.sv
module tb_array_scan_table;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned INDEX_W = 32;
  localparam int unsigned AW      = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               ready;
  logic               rd_en;
  logic [INDEX_W-1:0] rd_index;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_err;
  logic               scan_start;
  logic [INDEX_W-1:0] scan_index;
  logic               scan_busy;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_oob;

  int vectors     = 0;
  int miscompares = 0;

  array_scan_table #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .INDEX_W(INDEX_W), .INIT_BASE(1), .INIT_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_en(rd_en), .rd_index(rd_index),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .wr_err(wr_err),
    .scan_start(scan_start), .scan_index(scan_index), .scan_busy(scan_busy),
    .out_valid(out_valid), .out_data(out_data), .out_oob(out_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] ri;
    logic        wr;
    logic [31:0] wi;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
    logic        eo;
    logic        ee;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic rd, input logic [31:0] ri, input logic wr,
                              input logic [31:0] wi, input logic [31:0] wd,
                              input logic ev, input logic [31:0] ed,
                              input logic eo, input logic ee);
    vec_t v;
    v.rd = rd; v.ri = ri; v.wr = wr; v.wi = wi; v.wd = wd;
    v.ev = ev; v.ed = ed; v.eo = eo; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; rd_index = '0;
    wr_en = 1'b0; wr_index = '0; wr_data = '0;
    scan_start = 1'b0; scan_index = '0;
  endtask

  // Checks one output beat plus scan_busy.
  task automatic check_beat(input string name, input logic ev, input logic [31:0] ed,
                            input logic eo, input logic eb);
    check({name, "_valid"}, 32'(out_valid), 32'(ev));
    if (ev) check({name, "_data"}, out_data, ed);
    check({name, "_oob"}, 32'(out_oob), 32'(eo));
    check({name, "_busy"}, 32'(scan_busy), 32'(eb));
  endtask

  // Watchdog: the sequence is purely cycle-counted, this only guards a stuck clock.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] mm [DEPTH];
  int          q[$];
  logic        prev_busy;
  logic        ev, eo, eb, ee;
  logic [31:0] ed;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(scan_busy), 32'd0);
    check("rst_oob", 32'(out_oob), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_data", out_data, 32'd0);

    // Fill takes DEPTH cycles after release.
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("init_ready", 32'(ready), 32'(i == 4));
    end

    // Single reads, clamping, read-during-write and rejected writes.
    vt[0]  = mk(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0);
    vt[1]  = mk(1'b1, 32'd1, 1'b0, 32'd0, 32'd0, 1'b1, 32'd3, 1'b0, 1'b0);
    vt[2]  = mk(1'b1, 32'd2, 1'b0, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0, 1'b0);
    vt[3]  = mk(1'b1, 32'd3, 1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0);
    vt[4]  = mk(1'b1, 32'd9, 1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 1'b1, 1'b0);
    vt[5]  = mk(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 1'b1, 1'b0);
    vt[6]  = mk(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    vt[7]  = mk(1'b1, 32'd2, 1'b1, 32'd2, 32'hAA, 1'b1, 32'd5, 1'b0, 1'b0);
    vt[8]  = mk(1'b1, 32'd2, 1'b0, 32'd0, 32'd0, 1'b1, 32'hAA, 1'b0, 1'b0);
    vt[9]  = mk(1'b0, 32'd0, 1'b1, 32'd4, 32'h123, 1'b0, 32'd0, 1'b0, 1'b1);
    vt[10] = mk(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    vt[11] = mk(1'b1, 32'd3, 1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0);
    vt[12] = mk(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0);
    vt[13] = mk(1'b0, 32'd0, 1'b1, 32'd2, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0);
    vt[14] = mk(1'b1, 32'd2, 1'b0, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      rd_en = vt[i].rd; rd_index = vt[i].ri;
      wr_en = vt[i].wr; wr_index = vt[i].wi; wr_data = vt[i].wd;
      step();
      check("tbl_valid", 32'(out_valid), 32'(vt[i].ev));
      if (vt[i].ev) check("tbl_data", out_data, vt[i].ed);
      check("tbl_oob", 32'(out_oob), 32'(vt[i].eo));
      check("tbl_wr_err", 32'(wr_err), 32'(vt[i].ee));
    end
    idle_inputs();

    // Scan from 1 with a concurrent read held throughout.
    scan_start = 1'b1; scan_index = 32'd1; rd_en = 1'b1; rd_index = 32'd0;
    step();
    scan_start = 1'b0;
    check_beat("scan1_b0", 1'b1, 32'd3, 1'b0, 1'b1);
    step();
    check_beat("scan1_b1", 1'b1, 32'd5, 1'b0, 1'b1);
    step();
    check_beat("scan1_b2", 1'b1, 32'd7, 1'b0, 1'b1);
    step();
    check_beat("scan1_end", 1'b0, 32'd0, 1'b0, 1'b0);
    idle_inputs();
    step();
    check_beat("scan1_after", 1'b0, 32'd0, 1'b0, 1'b0);

    // Out-of-range scan start: one clamped beat, never busy.
    scan_start = 1'b1; scan_index = 32'd7;
    step();
    idle_inputs();
    check_beat("scan_oob_b0", 1'b1, 32'd7, 1'b1, 1'b0);
    step();
    check_beat("scan_oob_end", 1'b0, 32'd0, 1'b0, 1'b0);

    // Scan of the last entry only.
    scan_start = 1'b1; scan_index = 32'd3;
    step();
    idle_inputs();
    check_beat("scan_last_b0", 1'b1, 32'd7, 1'b0, 1'b1);
    step();
    check_beat("scan_last_end", 1'b0, 32'd0, 1'b0, 1'b0);

    // Write ahead of the scan pointer is observed.
    scan_start = 1'b1; scan_index = 32'd0;
    step();
    scan_start = 1'b0;
    check_beat("scanw_b0", 1'b1, 32'd1, 1'b0, 1'b1);
    wr_en = 1'b1; wr_index = 32'd3; wr_data = 32'h55;
    step();
    idle_inputs();
    check_beat("scanw_b1", 1'b1, 32'd3, 1'b0, 1'b1);
    step();
    check_beat("scanw_b2", 1'b1, 32'd5, 1'b0, 1'b1);
    step();
    check_beat("scanw_b3", 1'b1, 32'h55, 1'b0, 1'b1);
    step();
    check_beat("scanw_end", 1'b0, 32'd0, 1'b0, 1'b0);

    // Reset mid-scan, after the second beat.
    scan_start = 1'b1; scan_index = 32'd0;
    step();
    scan_start = 1'b0;
    step();
    check_beat("abort_b1", 1'b1, 32'd3, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(scan_busy), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_data", out_data, 32'd0);
    step();
    step();
    reset = 1'b0;
    // Requests during the refill must be ignored.
    rd_en = 1'b1; rd_index = 32'd1; scan_start = 1'b1; scan_index = 32'd0;
    wr_en = 1'b1; wr_index = 32'd0; wr_data = 32'hDEAD;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("reinit_ready", 32'(ready), 32'(i == 4));
      check("reinit_valid", 32'(out_valid), 32'd0);
      check("reinit_wr_err", 32'(wr_err), 32'd0);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_index = 32'(i);
      step();
      check("reinit_rd_valid", 32'(out_valid), 32'd1);
      check("reinit_rd_data", out_data, 32'(1 + 2 * i));
    end
    idle_inputs();
    step();

    // Random traffic against a table-level model.
    for (int k = 0; k < DEPTH; k++) mm[k] = 32'(1 + 2 * k);
    q.delete();
    prev_busy = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rd_en      = ($urandom_range(0, 1) == 1);
      rd_index   = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5));
      wr_en      = ($urandom_range(0, 9) < 3);
      wr_index   = 32'($urandom_range(0, 5));
      wr_data    = 32'($urandom);
      scan_start = ($urandom_range(0, 9) == 0);
      scan_index = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5));

      ev = 1'b0; eo = 1'b0; eb = 1'b0; ee = 1'b0; ed = '0;
      if (prev_busy) begin
        if (q.size() > 0) begin
          ed = mm[AW'(q.pop_front())];
          ev = 1'b1;
          eb = 1'b1;
        end
      end else if (scan_start) begin
        if (scan_index >= DEPTH) begin
          ev = 1'b1; eo = 1'b1; ed = mm[AW'(DEPTH - 1)];
        end else begin
          for (int k = int'(scan_index); k < int'(DEPTH); k++) q.push_back(k);
          ed = mm[AW'(q.pop_front())];
          ev = 1'b1;
          eb = 1'b1;
        end
      end else if (rd_en) begin
        ev = 1'b1;
        eo = (rd_index >= DEPTH);
        ed = eo ? mm[AW'(DEPTH - 1)] : mm[AW'(rd_index)];
      end
      if (wr_en) begin
        if (wr_index < DEPTH) mm[AW'(wr_index)] = wr_data;
        else ee = 1'b1;
      end
      prev_busy = eb;

      step();
      check_beat("rnd", ev, ed, eo, eb);
      check("rnd_wr_err", 32'(wr_err), 32'(ee));
      check("rnd_ready", 32'(ready), 32'd1);
    end
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
